// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master: producer/consumer side. slave: the FIFO itself.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO, DEPTH = 2**ADDR_WIDTH words.
// Status flags are decoded from the registered count; overflow and
// underflow pulse for one cycle after a rejected write / read.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; the
// default build gives a registered output with one-cycle read latency.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst_a,
    sync_fifo_param_if.slave   bus
);
    localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  rd_acc;
    logic                  wr_acc;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts
    // a write paired with an accepted read; an empty FIFO never reads.
    assign rd_acc = bus.rd_en && !empty_w;
    assign wr_acc = bus.wr_en && (!full_w || rd_acc);

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_a && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Captures the popped word; reads the old word when full with a
    // simultaneous write to the same slot.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

    // One-cycle error pulses for rejected operations.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en && !wr_acc;
            udf_q <= bus.rd_en && empty_w;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; the last popped word is held while empty.
    assign bus.data_out = empty_w ? dout_q : mem[rd_ptr];
`else
    assign bus.data_out = dout_q;
`endif

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_a;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) dut (
        .clk(clk), .rst_a(rst_a), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [$];
    logic [DW-1:0] last_pop;
    logic          exp_ovf;
    logic          exp_udf;

    function automatic logic [DW-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
        if (model.size() > 0) return model[0];
`endif
        return last_pop;
    endfunction

    function automatic logic [AW:0] exp_cnt();
        return (AW + 1)'(model.size());
    endfunction

    // One clock: drive inputs, take the edge, advance the model.
    task automatic cycle(input logic rst, input logic wr, input logic [DW-1:0] din,
                         input logic rd);
        logic rd_ok;
        logic wr_ok;
        rst_a = rst; bus.wr_en = wr; bus.data_in = din; bus.rd_en = rd;
        @(posedge clk);
        #1;
        if (rst) begin
            model.delete();
            last_pop = '0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            rd_ok = rd && (model.size() > 0);
            wr_ok = wr && ((model.size() < DEPTH) || rd_ok);
            if (rd_ok) last_pop = model.pop_front();
            if (wr_ok) model.push_back(din);
            exp_ovf = wr && !wr_ok;
            exp_udf = rd && !rd_ok;
        end
        rst_a = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        n_tests++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        n_tests++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
        n_tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", bus.overflow, bus.underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0);
            n_tests++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, exp_cnt()); end
            n_tests++; if (bus.almost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, bus.almost_full, (i >= 12)); end
            n_tests++; if (bus.full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.full, (i == DEPTH)); end
            n_tests++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL fill_dout got=%h exp=%h", bus.data_out, exp_dout()); end
        end
        n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL fill_final_count got=%0d exp=16", bus.count); end
    endtask

    task automatic drain(input string tag);
        while (model.size() > 0) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n_tests++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL %s_dout got=%h exp=%h", tag, bus.data_out, exp_dout()); end
            n_tests++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL %s_count got=%0d exp=%0d", tag, bus.count, exp_cnt()); end
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL %s_empty got=%b exp=1", tag, bus.empty); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] hold;
        hold = bus.data_out;
        cycle(1'b0, 1'b1, 8'hAA, 1'b0);
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b exp=1", bus.overflow); end
        n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        n_tests++; if (bus.data_out !== hold) begin n_fail++; $display("FAIL ovf_dout got=%h exp=%h", bus.data_out, hold); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got=%b exp=0", bus.overflow); end
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            n_tests++; if (bus.data_out !== 8'(i)) begin n_fail++; $display("FAIL ovf_order i=%0d got=%h exp=%h", i, bus.data_out, 8'(i)); end
            cycle(1'b0, 1'b0, '0, 1'b1);
`else
            cycle(1'b0, 1'b0, '0, 1'b1);
            n_tests++; if (bus.data_out !== 8'(i)) begin n_fail++; $display("FAIL ovf_order i=%0d got=%h exp=%h", i, bus.data_out, 8'(i)); end
`endif
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got=%b exp=1", bus.empty); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] hold;
        hold = bus.data_out;
        cycle(1'b0, 1'b1, 8'h5C, 1'b1);
        n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got=%b exp=1", bus.underflow); end
        n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL udf_count got=%0d exp=1", bus.count); end
`ifndef SYNC_FIFO_FWFT_EN
        n_tests++; if (bus.data_out !== hold) begin n_fail++; $display("FAIL udf_dout_hold got=%h exp=%h", bus.data_out, hold); end
`endif
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_one_cycle got=%b exp=0", bus.underflow); end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_tests++; if (bus.data_out !== 8'h5C) begin n_fail++; $display("FAIL udf_readback got=%h exp=5c", bus.data_out); end
        n_tests++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_after got=%b%b exp=10", bus.empty, bus.underflow); end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        n_tests++; if (bus.data_out !== 8'h01) begin n_fail++; $display("FAIL frw_head got=%h exp=01", bus.data_out); end
`endif
        cycle(1'b0, 1'b1, 8'h77, 1'b1);
        n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL frw_count got=%0d exp=16", bus.count); end
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL frw_ovf got=%b exp=0", bus.overflow); end
`ifndef SYNC_FIFO_FWFT_EN
        n_tests++; if (bus.data_out !== 8'h01) begin n_fail++; $display("FAIL frw_head got=%h exp=01", bus.data_out); end
`endif
        drain("frw");
        n_tests++; if (last_pop !== 8'h77 || bus.data_out !== 8'h77) begin n_fail++; $display("FAIL frw_last got=%h exp=77", bus.data_out); end
    endtask

    task automatic test_wrap();
        logic wr;
        logic rd;
        logic [DW-1:0] d;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (model.size() <= 3 && rd && !wr) rd = 1'b0;
            if (model.size() >= 9 && wr && !rd) wr = 1'b0;
            d = 8'($urandom);
            cycle(1'b0, wr, d, rd);
            n_tests++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL wrap_dout i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
            n_tests++; if (bus.count !== exp_cnt()) begin n_fail++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
            n_tests++; if (bus.almost_empty !== (model.size() <= 4)) begin n_fail++; $display("FAIL wrap_aempty i=%0d got=%b exp=%b", i, bus.almost_empty, (model.size() <= 4)); end
            n_tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_pulses i=%0d got=%b%b exp=00", i, bus.overflow, bus.underflow); end
        end
        drain("wrap");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_tests++; if (bus.count !== 5'd6) begin n_fail++; $display("FAIL rmid_pre got=%0d exp=6", bus.count); end
        cycle(1'b0, 1'b1, 8'h33, 1'b0);
        cycle(1'b1, 1'b1, 8'h44, 1'b1);
        n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty got=%b exp=1", bus.empty); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_dout got=%h exp=00", bus.data_out); end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_tests++; if (bus.underflow !== exp_udf || bus.underflow !== 1'b1) begin n_fail++; $display("FAIL rmid_udf got=%b exp=1", bus.underflow); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_dout_hold got=%h exp=00", bus.data_out); end
    endtask

    initial begin
        rst_a = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
        last_pop = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AFULL_THRESH, default 12, the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 4, the count at or below which almost_empty asserts.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_a  input  1  synchronous active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 data_out  output  DATA_WIDTH  read data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AFULL_THRESH.
REQ-015 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-016 count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse, write rejected.
REQ-018 underflow  output  1  one-cycle pulse, read rejected.

Function
REQ-019 A write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle); the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-020 A read SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-021 A read with empty=1 SHALL be rejected, even when a write is accepted in the same cycle.
REQ-022 count SHALL change by +1 on write-only, -1 on read-only, and 0 on simultaneous accept or no accept, and SHALL never leave 0..DEPTH.
REQ-023 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-024 overflow SHALL pulse high for exactly the cycle after a rejected write (wr_en=1, full=1, no accepted read); otherwise 0.
REQ-025 underflow SHALL pulse high for exactly the cycle after a rejected read (rd_en=1, empty=1); otherwise 0.
REQ-026 Rejected operations SHALL change no pointer, no count, no storage, and not data_out.
REQ-027 Storage SHALL be a DEPTH x DATA_WIDTH register array, written on clk with no read-during-write bypass hazard; reading slot N while writing slot N is impossible except when full with simultaneous read, where the old word is read.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strictly FIFO across wrap.

Reset
REQ-029 When rst_a=1 at a rising clk edge, wr_ptr, rd_ptr and count SHALL become 0, data_out SHALL become 0, and overflow and underflow SHALL become 0; all other inputs are ignored that cycle.
REQ-030 After reset: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset mid-operation SHALL discard all stored words; array contents need not be cleared.

Configuration
REQ-032 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-033 If SYNC_FIFO_FWFT_EN is defined: data_out SHALL combinationally show the word at rd_ptr while empty=0, and SHALL hold the last-popped value (0 after reset) while empty=1. An accepted read pops that word.
REQ-034 If SYNC_FIFO_FWFT_EN is undefined: data_out SHALL be registered; the word at rd_ptr SHALL appear on the clk edge after the accepted read (1-cycle latency) and hold until the next accepted read.

Verification
REQ-035 Reset, then write 0x01..0x10 on 16 cycles -> full=1 and count=16 after the last write; almost_full first asserts when count=12.
REQ-036 With the FIFO full, wr_en=1 with data 0xAA and rd_en=0 -> overflow=1 for one cycle, count stays 16, and the subsequent 16 reads return 0x01..0x10 in order.
REQ-037 With the FIFO empty, rd_en=1 and wr_en=1 with data 0x5C -> underflow=1 for one cycle, count=1, and the next read returns 0x5C.
REQ-038 With the FIFO full, simultaneous wr_en and rd_en with data 0x77 -> count stays 16, the head word 0x01 is returned, and 0x77 is returned last.
REQ-039 Wrap test: 40 interleaved random writes/reads, keeping count between 3 and 9 -> output sequence matches a scoreboard, almost_empty tracks count<=4, and there is no overflow or underflow.
REQ-040 Reset asserted with count=7 -> on the next cycle count=0, empty=1 and data_out=0; in non-FWFT mode a read issued 1 cycle later gives underflow=1.
